// File: rtl/async_arb_pkg.sv
// Shared constants, width helper and FSM state type for the async request arbiter.
package async_arb_pkg;

  localparam int unsigned DefaultN = 4;

  // Channel index width; a single bit is kept even for degenerate channel counts.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    StIdle,
    StGrant
  } arb_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus a history flop; flags one cycle per 0->1 level change.
module sync_edge_det (
  input  logic clk_des,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk_des or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/async_req_arbiter.sv
// Round-robin arbiter serving latched rising events from N asynchronous request lines.
module async_req_arbiter
  import async_arb_pkg::*;
#(
  parameter int unsigned N = DefaultN,
  localparam int unsigned ID_W = id_width(N)
) (
  input  logic            clk_des,
  input  logic            rst_n,
  input  logic [N-1:0]    req_async,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  input  logic            evt_ready,
  output logic [N-1:0]    pending,
  output logic [N-1:0]    overflow,
  input  logic            ovf_clr
);

  logic [N-1:0]    rise;
  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    overflow_q, overflow_d;
  logic [N-1:0]    clr_vec;
  logic [ID_W-1:0] evt_id_q;
  logic [ID_W-1:0] last_grant_q;
  logic [ID_W-1:0] sel_id, cand;
  logic            sel_found;
  logic            handshake;
  logic            load_grant;
  arb_state_e      state_q, state_d;

  for (genvar i = 0; i < N; i++) begin : g_sync
    sync_edge_det u_sync (
      .clk_des (clk_des),
      .rst_n   (rst_n),
      .din     (req_async[i]),
      .rise    (rise[i])
    );
  end

  // Round-robin search starting just above the last served channel.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = ID_W'((32'(last_grant_q) + k) % N);
      if (!sel_found && pending_q[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  always_ff @(posedge clk_des or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (sel_found) state_d = StGrant;
      StGrant: if (evt_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    evt_valid  = (state_q == StGrant);
    handshake  = evt_valid & evt_ready;
    load_grant = (state_q == StIdle) & sel_found;
  end

  // A rise landing on the clearing handshake re-arms the channel instead of overflowing.
  always_comb begin
    clr_vec    = handshake ? (N'(1) << evt_id_q) : '0;
    pending_d  = rise | (pending_q & ~clr_vec);
    overflow_d = (ovf_clr ? '0 : overflow_q) | (rise & pending_q & ~clr_vec);
  end

  always_ff @(posedge clk_des or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      overflow_q   <= '0;
      evt_id_q     <= '0;
      last_grant_q <= ID_W'(N - 1);
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      if (load_grant) evt_id_q <= sel_id;
      if (handshake) last_grant_q <= evt_id_q;
    end
  end

  assign evt_id   = evt_id_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule
